// File: rtl/fetch_queue_stage.sv
// Instruction-fetch stage: drives a 1-cycle-latency instruction memory and buffers
// returned instructions in a small prefetch queue handed to ID over valid/ready.
module fetch_queue_stage #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter int              QDEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        redirect_valid,
    input  logic [XLEN-1:0]             redirect_pc,
    output logic                        imem_req,
    output logic [XLEN-1:0]             imem_addr,
    input  logic [ILEN-1:0]             imem_rdata,
    output logic                        id_valid,
    input  logic                        id_ready,
    output logic [ILEN-1:0]             id_inst,
    output logic [XLEN-1:0]             id_pc,
    output logic [XLEN-1:0]             id_pc_next,
    output logic [XLEN-1:0]             pc_current,
    output logic [$clog2(QDEPTH+1)-1:0] q_count
);
    localparam int              AW   = $clog2(QDEPTH);
    localparam int              CW   = $clog2(QDEPTH+1);
    localparam int              OW   = CW + 1;
    localparam logic [OW-1:0]   QD   = OW'(QDEPTH);
    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [OW-1:0]   occ;
    logic            push;
    logic            pop;

    logic [ILEN-1:0] q_inst [QDEPTH];
    logic [XLEN-1:0] q_pc   [QDEPTH];

    // Eligibility counts the in-flight response so the queue can never overflow.
    assign occ      = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign imem_req = rst & ~redirect_valid & (occ < QD);
    assign imem_addr  = pc;
    assign pc_current = pc;
    assign q_count    = count;

    assign id_valid   = (count != '0);
    assign id_inst    = id_valid ? q_inst[rd_ptr] : '0;
    assign id_pc      = id_valid ? q_pc[rd_ptr] : '0;
    assign id_pc_next = id_valid ? q_pc[rd_ptr] + STEP : '0;

    // A redirect squashes both the returning response and any ID pop.
    assign push = inflight & ~redirect_valid;
    assign pop  = id_valid & id_ready & ~redirect_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                pc          <= pc + STEP;
                inflight_pc <= pc;
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Payload storage needs no reset: empty slots are masked at the output.
    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]   <= inflight_pc;
        end
    end

    assert property (@(posedge clk) disable iff (!rst) occ <= QD);

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage: per-cycle vector table plus hand-written
// sequences for PC wrap and asynchronous reset with a full queue.
module tb_fetch_queue_stage;
    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;

    logic        imem_req,  w_req;
    logic [31:0] imem_addr, w_addr;
    logic [31:0] imem_rdata, w_rdata;
    logic        id_valid,  w_vld;
    logic [31:0] id_inst,   w_inst;
    logic [31:0] id_pc,     w_pc;
    logic [31:0] id_pc_next, w_nxt;
    logic [31:0] pc_current, w_pcc;
    logic [2:0]  q_count,   w_cnt;

    int total = 0;
    int bad   = 0;

    fetch_queue_stage dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc),
        .id_pc_next(id_pc_next), .pc_current(pc_current), .q_count(q_count)
    );

    fetch_queue_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
        .id_valid(w_vld), .id_ready(id_ready), .id_inst(w_inst), .id_pc(w_pc),
        .id_pc_next(w_nxt), .pc_current(w_pcc), .q_count(w_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory: word contents = address >> 2.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr >> 2;
        if (w_req)    w_rdata    <= w_addr >> 2;
    end

    typedef struct {
        bit          start;
        bit          rdv;
        logic [31:0] rpc;
        bit          rdy;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_vld;
        logic [31:0] e_pc;
        int          e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit st, input bit rdv, input logic [31:0] rpc, input bit rdy,
                       input bit e_req, input logic [31:0] e_addr, input bit e_vld,
                       input logic [31:0] e_pc, input int e_cnt);
        vec_t v;
        v.start = st; v.rdv = rdv; v.rpc = rpc; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_pc = e_pc; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    initial begin
        logic [31:0] e_inst, e_nxt;
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;

        @(negedge clk); #1;
        chk("rst imem_req", 64'(imem_req), 64'(0));
        chk("rst id_valid", 64'(id_valid), 64'(0));
        chk("rst q_count",  64'(q_count),  64'(0));
        chk("rst pc",       64'(pc_current), 64'(0));
        chk("rst wrap pc",  64'(w_pcc),    64'(32'hFFFF_FFF8));

        // Streaming with id_ready=1
        add(1,0,0,1, 1,0,  0,0,0);
        add(0,0,0,1, 1,4,  0,0,0);
        add(0,0,0,1, 1,8,  1,0,1);
        add(0,0,0,1, 1,12, 1,4,1);
        add(0,0,0,1, 1,16, 1,8,1);
        // Backpressure fills the queue, then drains in order
        add(1,0,0,0, 1,0,  0,0,0);
        add(0,0,0,0, 1,4,  0,0,0);
        add(0,0,0,0, 1,8,  1,0,1);
        add(0,0,0,0, 1,12, 1,0,2);
        add(0,0,0,0, 0,16, 1,0,3);
        add(0,0,0,0, 0,16, 1,0,4);
        add(0,0,0,1, 0,16, 1,0,4);
        add(0,0,0,1, 1,16, 1,4,3);
        add(0,0,0,1, 1,20, 1,8,2);
        add(0,0,0,1, 1,24, 1,12,2);
        add(0,0,0,1, 1,28, 1,16,2);
        // Redirect with 3 queued + 1 in flight
        add(1,0,0,0, 1,0,  0,0,0);
        add(0,0,0,0, 1,4,  0,0,0);
        add(0,0,0,0, 1,8,  1,0,1);
        add(0,0,0,0, 1,12, 1,0,2);
        add(0,1,32'h100,0, 0,16, 1,0,3);
        add(0,0,0,0, 1,32'h100, 0,0,0);
        add(0,0,0,0, 1,32'h104, 0,0,0);
        add(0,0,0,0, 1,32'h108, 1,32'h100,1);
        // Redirect during pop, then back-to-back redirects
        add(1,0,0,1, 1,0,  0,0,0);
        add(0,0,0,1, 1,4,  0,0,0);
        add(0,0,0,1, 1,8,  1,0,1);
        add(0,1,32'h200,1, 0,12, 1,4,1);
        add(0,1,32'h300,1, 0,32'h200, 0,0,0);
        add(0,0,0,1, 1,32'h300, 0,0,0);
        add(0,0,0,1, 1,32'h304, 0,0,0);
        add(0,0,0,1, 1,32'h308, 1,32'h300,1);

        foreach (vecs[i]) begin
            if (vecs[i].start) begin
                rst = 1'b0; redirect_valid = 1'b0; id_ready = 1'b0;
                repeat (2) @(negedge clk);
                rst = 1'b1;
            end
            redirect_valid = vecs[i].rdv;
            redirect_pc    = vecs[i].rpc;
            id_ready       = vecs[i].rdy;
            #1;
            e_inst = vecs[i].e_vld ? vecs[i].e_pc >> 2 : 32'd0;
            e_nxt  = vecs[i].e_vld ? vecs[i].e_pc + 32'd4 : 32'd0;
            chk($sformatf("v%0d imem_req", i),   64'(imem_req),   64'(vecs[i].e_req));
            chk($sformatf("v%0d imem_addr", i),  64'(imem_addr),  64'(vecs[i].e_addr));
            chk($sformatf("v%0d id_valid", i),   64'(id_valid),   64'(vecs[i].e_vld));
            chk($sformatf("v%0d id_pc", i),      64'(id_pc),      64'(vecs[i].e_vld ? vecs[i].e_pc : 32'd0));
            chk($sformatf("v%0d id_inst", i),    64'(id_inst),    64'(e_inst));
            chk($sformatf("v%0d id_pc_next", i), 64'(id_pc_next), 64'(e_nxt));
            chk($sformatf("v%0d q_count", i),    64'(q_count),    64'(vecs[i].e_cnt));
            @(negedge clk);
        end

        // PC wrap at the top of the address space
        rst = 1'b0; redirect_valid = 1'b0; id_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1; id_ready = 1'b1;
        #1; chk("wrap addr c0", 64'(w_addr), 64'(32'hFFFF_FFF8));
        @(negedge clk); #1; chk("wrap addr c1", 64'(w_addr), 64'(32'hFFFF_FFFC));
        @(negedge clk); #1; chk("wrap addr c2", 64'(w_addr), 64'(32'h0));
        chk("wrap id_pc c2",   64'(w_pc),  64'(32'hFFFF_FFF8));
        chk("wrap next c2",    64'(w_nxt), 64'(32'hFFFF_FFFC));
        @(negedge clk); #1;
        chk("wrap id_pc c3",   64'(w_pc),  64'(32'hFFFF_FFFC));
        chk("wrap next c3",    64'(w_nxt), 64'(32'h0));
        chk("wrap inst c3",    64'(w_inst), 64'(32'h3FFF_FFFF));

        // Async reset with a full queue, between clock edges
        @(negedge clk);
        rst = 1'b0; id_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        #1; chk("full q_count", 64'(q_count), 64'(4));
        chk("full imem_req", 64'(imem_req), 64'(0));
        #2; rst = 1'b0; #1;
        chk("async imem_req",   64'(imem_req),   64'(0));
        chk("async imem_addr",  64'(imem_addr),  64'(0));
        chk("async id_valid",   64'(id_valid),   64'(0));
        chk("async id_inst",    64'(id_inst),    64'(0));
        chk("async id_pc",      64'(id_pc),      64'(0));
        chk("async id_pc_next", 64'(id_pc_next), 64'(0));
        chk("async pc",         64'(pc_current), 64'(0));
        chk("async q_count",    64'(q_count),    64'(0));
        chk("async wrap pc",    64'(w_pcc),      64'(32'hFFFF_FFF8));
        @(negedge clk); rst = 1'b1; #1;
        chk("rel imem_req",  64'(imem_req), 64'(1));
        chk("rel imem_addr", 64'(imem_addr), 64'(0));
        chk("rel wrap addr", 64'(w_addr), 64'(32'hFFFF_FFF8));
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
- Parametrised instruction-fetch stage for the pipelined MIPS core; successor of the single-register IF stage.
- Holds the fetch PC and issues requests to a synchronous instruction memory (1-cycle read latency).
- Buffers returned instructions in a QDEPTH-entry prefetch queue, presented to ID with a valid/ready handshake.
- Supports redirect (branch/jump) with queue flush and squash of the in-flight memory response.

Parameters:
XLEN, 32, PC/address width in bits
ILEN, 32, instruction width in bits
QDEPTH, 4, prefetch queue entries; power of 2, >= 2
RESET_PC, 0, fetch PC loaded on reset
PC_STEP, 4, PC increment per sequential fetch

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
redirect_valid  in  1  branch/jump taken this cycle
redirect_pc  in  XLEN  new fetch target
imem_req  out  1  read request this cycle
imem_addr  out  XLEN  read address (= fetch PC)
imem_rdata  in  ILEN  read data, valid the cycle after an accepted imem_req
id_valid  out  1  queue head valid
id_ready  in  1  ID accepts head this cycle
id_inst  out  ILEN  head instruction; 0 when empty
id_pc  out  XLEN  head instruction address; 0 when empty
id_pc_next  out  XLEN  id_pc + PC_STEP, mod 2^XLEN; 0 when empty
pc_current  out  XLEN  current fetch PC register
q_count  out  $clog2(QDEPTH+1)  occupied queue entries

Behaviour:
- Reset (rst=0, async): pc = RESET_PC; queue empty; in-flight flag cleared; q_count = 0; id_valid = 0; id_inst/id_pc/id_pc_next = 0; imem_req = 0 while rst = 0. Applies at any time, including mid-flush or with a full queue.
- State: pc; inflight (1 bit: request issued last cycle); inflight_pc; queue (rd/wr pointers, count).
- imem_req = rst & ~redirect_valid & (count + inflight < QDEPTH), using registered state only. imem_addr = pc.
- On accepted req: pc <= pc + PC_STEP (wraps mod 2^XLEN); inflight <= 1; inflight_pc <= pc. Otherwise inflight <= 0.
- Response: when inflight = 1 and no redirect this cycle, {imem_rdata, inflight_pc} is pushed at the clock edge.
- Head is visible from the cycle after the push; there is no same-cycle bypass.
- Pop: id_valid & id_ready at the edge. id_valid = (count != 0). Push and pop may occur in the same cycle; count is unchanged.
- A pop frees its slot for request eligibility from the next cycle.
- Overflow is impossible by construction: assert count + inflight <= QDEPTH.
- Redirect (redirect_valid = 1): at the edge, the queue is emptied, any in-flight response is discarded (not pushed), inflight <= 0, and pc <= redirect_pc. No request is issued in the redirect cycle.
  - Redirect overrides a simultaneous pop or push.
  - Back-to-back redirects: the last one wins.
- Latency:
  - First request in the cycle rst rises (cycle 0); first id_valid in cycle 2.
  - Redirect in cycle R: request in R+1; id_valid for target in R+3.
- Throughput: 1 instruction/cycle sustained with id_ready held 1.
- Pointers wrap modulo QDEPTH. Queue data is not required to be cleared on flush.

Test Plan:
- Reset release, id_ready=1, imem returns addr>>2 -> imem_addr 0,4,8,... every cycle; id_valid from cycle 2 with id_pc 0,4,8, id_pc_next 4,8,12, one per cycle.
- id_ready=0 from start -> exactly 4 requests (addr 0..12), then imem_req=0, q_count=4. Raise id_ready -> pops 0,4,8,12 in order; requests resume at 16 the cycle after the first pop.
- Redirect to 0x100 while queue holds 3 entries plus one in flight -> q_count=0 and id_valid=0 next cycle; in-flight data never appears at ID; next imem_addr=0x100; id_pc=0x100 at R+3.
- Redirect in the same cycle as a pop, and two consecutive redirects (0x200 then 0x300) -> queue empty; fetch resumes at 0x300 only.
- RESET_PC=0xFFFFFFF8 -> fetch addrs 0xFFFFFFF8, 0xFFFFFFFC, 0x0; the 0xFFFFFFFC entry has id_pc_next=0.
- Assert rst=0 mid-stream with a full queue -> all outputs zero immediately, without a clock edge; after release, first imem_addr=RESET_PC.
